// File: rtl/dkongjr_obj_dma_if.sv
// dkongjr_obj_dma_if
// Groups the start/done handshake, the Z80 bus request/grant pair and the two
// RAM ports used by the object DMA engine. The master modport is the DMA side.
// The slave modport is the system side: the CPU glue and both RAMs.
// Member names follow the engine's pin names, so the direction prefixes are
// seen from the DMA engine.

interface dkongjr_obj_dma_if;
  logic       I_START;
  logic       O_BUSRQ;
  logic       I_BUSAK;
  logic [9:0] O_SRC_ADDR;
  logic       O_SRC_CE;
  logic [7:0] I_SRC_DATA;
  logic [9:0] O_DST_ADDR;
  logic [7:0] O_DST_D;
  logic       O_DST_CE;
  logic       O_DST_WE;
  logic       O_BUSY;
  logic       O_DONE;

  modport master (
    input  I_START,
    input  I_BUSAK,
    input  I_SRC_DATA,
    output O_BUSRQ,
    output O_SRC_ADDR,
    output O_SRC_CE,
    output O_DST_ADDR,
    output O_DST_D,
    output O_DST_CE,
    output O_DST_WE,
    output O_BUSY,
    output O_DONE
  );

  modport slave (
    output I_START,
    output I_BUSAK,
    output I_SRC_DATA,
    input  O_BUSRQ,
    input  O_SRC_ADDR,
    input  O_SRC_CE,
    input  O_DST_ADDR,
    input  O_DST_D,
    input  O_DST_CE,
    input  O_DST_WE,
    input  O_BUSY,
    input  O_DONE
  );
endinterface

// File: rtl/dkongjr_obj_dma.sv
// dkongjr_obj_dma
// Sprite/object DMA engine for the Donkey Kong Jr core. A start strobe
// requests the Z80 bus, copies LEN bytes from work RAM port B, starting at
// SRC_BASE, into object RAM starting at DST_BASE. It moves one byte per clock.
// When the copy ends it releases the bus and pulses done.
//
// Build option: DKJR_OBJDMA_BUSRQ_EN
//   defined   - the engine waits for I_BUSAK before copying. A low I_BUSAK
//               during the copy pauses new reads.
//   undefined - I_BUSAK is ignored and treated as granted. O_BUSRQ stays 0.
//               The request phase lasts a single cycle.
//
// Every output except O_DST_D is a register. Each register is computed from
// the current state, so it shows that state one cycle later. O_DST_D passes
// the work RAM read data straight through, so the byte and its write strobe
// line up in the same cycle.

module dkongjr_obj_dma #(
  parameter int         LEN      = 384,
  parameter logic [9:0] SRC_BASE = 10'h100,
  parameter logic [9:0] DST_BASE = 10'h000
) (
  input logic               I_CLK,
  input logic               I_RST,
  dkongjr_obj_dma_if.master bus
);

  localparam int            CW   = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] rd_cnt, rd_cnt_d;
  logic [CW-1:0] wr_cnt, wr_cnt_d;
  logic          pending, pending_d;

  logic          busrq_q, busrq_d;
  logic          src_ce_q, src_ce_d;
  logic [9:0]    src_addr_q, src_addr_d;
  logic          dst_ce_q, dst_ce_d;
  logic          dst_we_q, dst_we_d;
  logic [9:0]    dst_addr_q, dst_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          grant;
  logic          req_en;

`ifdef DKJR_OBJDMA_BUSRQ_EN
  assign grant  = bus.I_BUSAK;
  assign req_en = 1'b1;
`else
  assign grant  = bus.I_BUSAK | 1'b1;
  assign req_en = 1'b0;
`endif

  // Next-state and next-output logic. A read issued last cycle (src_ce_q) is
  // written now, whatever state the FSM has moved on to.
  always_comb begin
    state_d    = state;
    rd_cnt_d   = rd_cnt;
    wr_cnt_d   = wr_cnt;
    pending_d  = pending;
    busrq_d    = 1'b0;
    src_ce_d   = 1'b0;
    src_addr_d = src_addr_q;
    dst_ce_d   = 1'b0;
    dst_we_d   = 1'b0;
    dst_addr_d = dst_addr_q;
    busy_d     = (state != ST_IDLE);
    done_d     = 1'b0;

    if (state != ST_IDLE && bus.I_START) begin
      pending_d = 1'b1;
    end

    if (src_ce_q) begin
      dst_ce_d   = 1'b1;
      dst_we_d   = 1'b1;
      dst_addr_d = DST_BASE + 10'(wr_cnt);
      wr_cnt_d   = wr_cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (bus.I_START) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        busrq_d  = req_en;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        if (grant) begin
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        busrq_d = req_en;
        if (grant) begin
          src_ce_d   = 1'b1;
          src_addr_d = SRC_BASE + 10'(rd_cnt);
          rd_cnt_d   = rd_cnt + 1'b1;
          if (rd_cnt == LAST) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        busrq_d = req_en;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        done_d = 1'b1;
        if (pending || bus.I_START) begin
          state_d   = ST_REQ;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, transfer counters and pending-start flag.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state   <= ST_IDLE;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_d;
      rd_cnt  <= rd_cnt_d;
      wr_cnt  <= wr_cnt_d;
      pending <= pending_d;
    end
  end

  // Output registers. All of them clear at once on reset, so a reset in the
  // middle of a copy drops the bus request and stops writes at once.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      busrq_q    <= 1'b0;
      src_ce_q   <= 1'b0;
      src_addr_q <= '0;
      dst_ce_q   <= 1'b0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busrq_q    <= busrq_d;
      src_ce_q   <= src_ce_d;
      src_addr_q <= src_addr_d;
      dst_ce_q   <= dst_ce_d;
      dst_we_q   <= dst_we_d;
      dst_addr_q <= dst_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.O_BUSRQ    = busrq_q;
  assign bus.O_SRC_CE   = src_ce_q;
  assign bus.O_SRC_ADDR = src_addr_q;
  assign bus.O_DST_CE   = dst_ce_q;
  assign bus.O_DST_WE   = dst_we_q;
  assign bus.O_DST_ADDR = dst_addr_q;
  assign bus.O_DST_D    = bus.I_SRC_DATA;
  assign bus.O_BUSY     = busy_q;
  assign bus.O_DONE     = done_q;

endmodule
